// File: rtl/de0_nano_burst_memory_pkg.sv
// Shared definitions for the burst memory slave: FSM state encoding and the
// legal read-latency range.
package de0_nano_burst_memory_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2
   } bm_state_t;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 2;

   // Clamps a requested latency onto the supported range.
   function automatic int legal_read_latency(input int lat);
      return (lat >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;
   endfunction

endpackage

// File: rtl/de0_nano_bram_be.sv
// Single-port byte-enabled block RAM with synchronous read. Out-of-range
// addresses read as zero and ignore writes; a read during write returns old data.
module de0_nano_bram_be #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 5120,
   parameter int ADDR_W    = 13,
   parameter     INIT_FILE = "de0_nano_burst_memory.hex"
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

   logic in_range;

   assign in_range = ({1'b0, addr} < DEPTH_X);

   always_ff @(posedge clk) begin
      if (en) begin
         if (we && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be[b]) begin
                  mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end
         rdata <= in_range ? mem[addr] : '0;
      end
   end

endmodule

// File: rtl/de0_nano_burst_memory.sv
// Avalon-MM style burst memory slave: burst FSM, beat address/counter and
// read-latency pipeline wrapped around a byte-enabled block RAM.
module de0_nano_burst_memory
   import de0_nano_burst_memory_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 5120,
   parameter int ADDR_W       = 13,
   parameter int BURST_W      = 4,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "de0_nano_burst_memory.hex"
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   input  logic [BURST_W-1:0]    burstcount,
   input  logic                  clken,
   input  logic                  reset_req,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest
);

   localparam int RL = legal_read_latency(READ_LATENCY);

   bm_state_t            state_q, state_d;
   logic [ADDR_W-1:0]    beat_addr_q, beat_addr_d;
   logic [BURST_W-1:0]   beats_left_q, beats_left_d;
   logic [BURST_W-1:0]   burst_eff;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_rdata;
   logic [RL-1:0]        rd_vld_q;
   logic                 eff_en;
   logic                 rd_issue;
   logic                 wr_issue;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   assign eff_en    = clken & ~reset_req;
   assign burst_eff = (burstcount == '0) ? BURST_W'(1) : burstcount;

   // Beat 0 of any burst is served straight from the bus inputs in IDLE;
   // later beats come from the latched beat address.
   always_comb begin
      state_d      = state_q;
      beat_addr_d  = beat_addr_q;
      beats_left_d = beats_left_q;
      mem_addr     = beat_addr_q;
      rd_issue     = 1'b0;
      wr_issue     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            mem_addr = address;
            if (chipselect && write) begin
               wr_issue     = 1'b1;
               beat_addr_d  = next_addr(address);
               beats_left_d = burst_eff - BURST_W'(1);
               if (burst_eff > BURST_W'(1)) state_d = ST_WR_BURST;
            end else if (chipselect && read) begin
               rd_issue     = 1'b1;
               beat_addr_d  = next_addr(address);
               beats_left_d = burst_eff - BURST_W'(1);
               if (burst_eff > BURST_W'(1)) state_d = ST_RD_BURST;
            end
         end
         ST_RD_BURST: begin
            rd_issue     = 1'b1;
            beat_addr_d  = next_addr(beat_addr_q);
            beats_left_d = beats_left_q - BURST_W'(1);
            if (beats_left_q <= BURST_W'(1)) state_d = ST_IDLE;
         end
         ST_WR_BURST: begin
            if (write) begin
               wr_issue     = 1'b1;
               beat_addr_d  = next_addr(beat_addr_q);
               beats_left_d = beats_left_q - BURST_W'(1);
               if (beats_left_q <= BURST_W'(1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         beat_addr_q  <= '0;
         beats_left_q <= '0;
         rd_vld_q     <= '0;
      end else if (eff_en) begin
         state_q      <= state_d;
         beat_addr_q  <= beat_addr_d;
         beats_left_q <= beats_left_d;
         rd_vld_q[0]  <= rd_issue;
         for (int i = 1; i < RL; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
         end
      end
   end

   de0_nano_bram_be #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_bram (
      .clk   (clk),
      .en    (eff_en & (rd_issue | wr_issue)),
      .we    (wr_issue),
      .be    (byteenable),
      .addr  (mem_addr),
      .wdata (writedata),
      .rdata (mem_rdata)
   );

   // The valid is gated by the enable so a beat stuck in the pipe during a
   // freeze is presented exactly once, on the next enabled cycle.
   assign readdatavalid = rd_vld_q[RL-1] & eff_en;
   assign waitrequest   = reset_n & (~eff_en | (state_q == ST_RD_BURST));

   generate
      if (RL == 1) begin : g_rl1
         assign readdata = rd_vld_q[0] ? mem_rdata : '0;
      end else begin : g_rl2
         logic [DATA_W-1:0] rd_data_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_data_q <= '0;
            end else if (eff_en) begin
               rd_data_q <= mem_rdata;
            end
         end
         assign readdata = rd_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_de0_nano_burst_memory.sv
// Directed bench for de0_nano_burst_memory; two instances (read latency 1 and 2)
// share one bus so every write lands in both memories.
module tb_de0_nano_burst_memory;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [12:0] address;
   logic [3:0]  byteenable;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  burstcount;
   logic        clken;
   logic        reset_req;
   logic [31:0] rd1, rd2;
   logic        rdv1, rdv2;
   logic        wr1, wr2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] cap_d1 [16];
   logic [31:0] cap_d2 [16];
   int          cap_c1 [16];
   int          cap_c2 [16];
   int          cap_n1, cap_n2, wait_n;

   always #5 clk = ~clk;

   de0_nano_burst_memory #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .burstcount(burstcount), .clken(clken), .reset_req(reset_req),
      .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1));

   de0_nano_burst_memory #(.READ_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .burstcount(burstcount), .clken(clken), .reset_req(reset_req),
      .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      burstcount = 4'd1;
      byteenable = 4'hF;
   endtask

   task automatic write_single(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
      chipselect = 1'b1; write = 1'b1; read = 1'b0;
      address = a; writedata = d; byteenable = be; burstcount = 4'd1;
      step();
      idle_bus();
   endtask

   // Runs ncyc cycles starting with whatever command the caller placed on the
   // bus, recording every valid beat of both instances with its cycle index.
   task automatic run_capture(input int ncyc, input int stall_a, input int stall_b);
      cap_n1 = 0; cap_n2 = 0; wait_n = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) idle_bus();
         clken = !(c == stall_a || c == stall_b);
         @(negedge clk);
         if (rdv1) begin
            if (cap_n1 < 16) begin cap_d1[cap_n1] = rd1; cap_c1[cap_n1] = c; end
            cap_n1++;
         end
         if (rdv2) begin
            if (cap_n2 < 16) begin cap_d2[cap_n2] = rd2; cap_c2[cap_n2] = c; end
            cap_n2++;
         end
         if (wr1) wait_n++;
         step();
      end
      clken = 1'b1;
   endtask

   task automatic read_one(input logic [12:0] a, input logic [3:0] bc);
      chipselect = 1'b1; read = 1'b1; write = 1'b0;
      address = a; burstcount = bc;
      run_capture(5, -1, -1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; clken = 1'b0; reset_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (rdv1 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rdv1 got %b want 0", rdv1); end
      n_cmp++; if (rdv2 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rdv2 got %b want 0", rdv2); end
      n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_rd1 got %h want 0", rd1); end
      n_cmp++; if (rd2 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_rd2 got %h want 0", rd2); end
      n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wait got %b want 0", wr1); end
      clken = 1'b1;
      step(); step();
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_wait got %b want 0", wr1); end
      step();
      clken = 1'b0; #1;
      n_cmp++; if (wr1 !== 1'b1) begin n_bad++; $display("[TB] FAIL clken_wait got %b want 1", wr1); end
      clken = 1'b1; reset_req = 1'b1; #1;
      n_cmp++; if (wr2 !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_req_wait got %b want 1", wr2); end
      reset_req = 1'b0; #1;
      n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL unfrozen_wait got %b want 0", wr1); end
      step();
   endtask

   task automatic test_single_rw();
      write_single(13'd5, 32'hDEADBEEF, 4'hF);
      chipselect = 1'b1; read = 1'b1; address = 13'd5; burstcount = 4'd1;
      @(negedge clk);
      n_cmp++; if (rdv1 !== 1'b0) begin n_bad++; $display("[TB] FAIL single_issue_rdv got %b want 0", rdv1); end
      step();
      idle_bus();
      @(negedge clk);
      n_cmp++; if (rdv1 !== 1'b1) begin n_bad++; $display("[TB] FAIL single_rl1_rdv got %b want 1", rdv1); end
      n_cmp++; if (rd1 !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL single_rl1_data got %h want deadbeef", rd1); end
      n_cmp++; if (rdv2 !== 1'b0) begin n_bad++; $display("[TB] FAIL single_rl2_early got %b want 0", rdv2); end
      step();
      @(negedge clk);
      n_cmp++; if (rdv1 !== 1'b0) begin n_bad++; $display("[TB] FAIL single_rl1_once got %b want 0", rdv1); end
      n_cmp++; if (rdv2 !== 1'b1) begin n_bad++; $display("[TB] FAIL single_rl2_rdv got %b want 1", rdv2); end
      n_cmp++; if (rd2 !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL single_rl2_data got %h want deadbeef", rd2); end
      step();
   endtask

   task automatic test_wrap_burst();
      chipselect = 1'b1; write = 1'b1; address = 13'd5118; burstcount = 4'd4; writedata = 32'd1;
      @(negedge clk);
      n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL wrburst_cmd_wait got %b want 0", wr1); end
      step();
      chipselect = 1'b0; address = 13'd0;
      for (int i = 2; i <= 4; i++) begin
         writedata = 32'(i);
         @(negedge clk);
         n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL wrburst_beat%0d_wait got %b want 0", i, wr1); end
         step();
      end
      idle_bus();
      chipselect = 1'b1; read = 1'b1; address = 13'd5118; burstcount = 4'd4;
      run_capture(10, -1, -1);
      n_cmp++; if (cap_n1 !== 4) begin n_bad++; $display("[TB] FAIL rdburst_count got %0d want 4", cap_n1); end
      n_cmp++; if (wait_n !== 3) begin n_bad++; $display("[TB] FAIL rdburst_wait_cycles got %0d want 3", wait_n); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (cap_d1[i] !== 32'(i + 1)) begin n_bad++; $display("[TB] FAIL rdburst_data%0d got %h want %h", i, cap_d1[i], i + 1); end
         n_cmp++; if (cap_c1[i] !== i + 1) begin n_bad++; $display("[TB] FAIL rdburst_cycle%0d got %0d want %0d", i, cap_c1[i], i + 1); end
      end
      n_cmp++; if (cap_n2 !== 4) begin n_bad++; $display("[TB] FAIL rdburst_rl2_count got %0d want 4", cap_n2); end
      n_cmp++; if (cap_d2[3] !== 32'd4) begin n_bad++; $display("[TB] FAIL rdburst_rl2_last got %h want 4", cap_d2[3]); end
   endtask

   task automatic test_byteenable();
      write_single(13'd7, 32'h11223344, 4'hF);
      write_single(13'd7, 32'hAABBCCDD, 4'b0101);
      read_one(13'd7, 4'd1);
      n_cmp++; if (cap_n1 !== 1) begin n_bad++; $display("[TB] FAIL be_count got %0d want 1", cap_n1); end
      n_cmp++; if (cap_d1[0] !== 32'h11BB33DD) begin n_bad++; $display("[TB] FAIL be_merge got %h want 11bb33dd", cap_d1[0]); end
      write_single(13'd7, 32'hFFFFFFFF, 4'b0000);
      read_one(13'd7, 4'd1);
      n_cmp++; if (cap_d1[0] !== 32'h11BB33DD) begin n_bad++; $display("[TB] FAIL be_none got %h want 11bb33dd", cap_d1[0]); end
   endtask

   task automatic test_latency2_stall();
      int exp_c1 [8];
      int exp_c2 [8];
      exp_c1 = '{1, 2, 5, 6, 7, 8, 9, 10};
      exp_c2 = '{2, 5, 6, 7, 8, 9, 10, 11};
      chipselect = 1'b1; write = 1'b1; address = 13'd100; burstcount = 4'd8; writedata = 32'hA0;
      step();
      chipselect = 1'b0;
      for (int i = 1; i < 8; i++) begin
         writedata = 32'hA0 + 32'(i);
         step();
      end
      idle_bus();
      chipselect = 1'b1; read = 1'b1; address = 13'd100; burstcount = 4'd8;
      run_capture(16, 3, 4);
      n_cmp++; if (cap_n2 !== 8) begin n_bad++; $display("[TB] FAIL stall_rl2_count got %0d want 8", cap_n2); end
      n_cmp++; if (cap_n1 !== 8) begin n_bad++; $display("[TB] FAIL stall_rl1_count got %0d want 8", cap_n1); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (cap_d2[i] !== 32'hA0 + 32'(i)) begin n_bad++; $display("[TB] FAIL stall_rl2_data%0d got %h want %h", i, cap_d2[i], 32'hA0 + i); end
         n_cmp++; if (cap_c2[i] !== exp_c2[i]) begin n_bad++; $display("[TB] FAIL stall_rl2_cycle%0d got %0d want %0d", i, cap_c2[i], exp_c2[i]); end
         n_cmp++; if (cap_c1[i] !== exp_c1[i]) begin n_bad++; $display("[TB] FAIL stall_rl1_cycle%0d got %0d want %0d", i, cap_c1[i], exp_c1[i]); end
      end
   endtask

   task automatic test_reset_mid_burst();
      int stray;
      stray = 0;
      chipselect = 1'b1; read = 1'b1; address = 13'd100; burstcount = 4'd8;
      step();
      idle_bus();
      step(); step();
      reset_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (rdv1 !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_rdv1 got %b want 0", rdv1); end
      n_cmp++; if (rdv2 !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_rdv2 got %b want 0", rdv2); end
      n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_wait got %b want 0", wr1); end
      step();
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (wr1 !== 1'b0) begin n_bad++; $display("[TB] FAIL postrst_wait got %b want 0", wr1); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rdv1 || rdv2 || wr1) stray++;
         step();
      end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("[TB] FAIL postrst_quiet got %0d want 0", stray); end
      read_one(13'd103, 4'd1);
      n_cmp++; if (cap_d1[0] !== 32'hA3) begin n_bad++; $display("[TB] FAIL postrst_rl1_data got %h want a3", cap_d1[0]); end
      n_cmp++; if (cap_n2 !== 1 || cap_d2[0] !== 32'hA3) begin n_bad++; $display("[TB] FAIL postrst_rl2_data got %0d/%h want 1/a3", cap_n2, cap_d2[0]); end
   endtask

   task automatic test_out_of_range();
      write_single(13'd880, 32'h00000880, 4'hF);
      write_single(13'd1904, 32'h00001904, 4'hF);
      read_one(13'd6000, 4'd1);
      n_cmp++; if (cap_n1 !== 1) begin n_bad++; $display("[TB] FAIL oor_rdv got %0d want 1", cap_n1); end
      n_cmp++; if (cap_d1[0] !== 32'h0) begin n_bad++; $display("[TB] FAIL oor_data got %h want 0", cap_d1[0]); end
      write_single(13'd6000, 32'h12345678, 4'hF);
      read_one(13'd880, 4'd1);
      n_cmp++; if (cap_d1[0] !== 32'h00000880) begin n_bad++; $display("[TB] FAIL oor_alias880 got %h want 880", cap_d1[0]); end
      read_one(13'd1904, 4'd1);
      n_cmp++; if (cap_d1[0] !== 32'h00001904) begin n_bad++; $display("[TB] FAIL oor_alias1904 got %h want 1904", cap_d1[0]); end
   endtask

   task automatic test_misc();
      read_one(13'd5, 4'd0);
      n_cmp++; if (cap_n1 !== 1) begin n_bad++; $display("[TB] FAIL burst0_count got %0d want 1", cap_n1); end
      n_cmp++; if (wait_n !== 0) begin n_bad++; $display("[TB] FAIL burst0_wait got %0d want 0", wait_n); end
      chipselect = 1'b1; read = 1'b1; write = 1'b1;
      address = 13'd9; writedata = 32'h00000055; burstcount = 4'd1;
      run_capture(4, -1, -1);
      n_cmp++; if (cap_n1 !== 0) begin n_bad++; $display("[TB] FAIL priority_no_read got %0d want 0", cap_n1); end
      read_one(13'd9, 4'd1);
      n_cmp++; if (cap_d1[0] !== 32'h00000055) begin n_bad++; $display("[TB] FAIL priority_write got %h want 55", cap_d1[0]); end
   endtask

   initial begin
      idle_bus();
      address   = '0;
      writedata = '0;
      reset_n   = 1'b0;
      clken     = 1'b1;
      reset_req = 1'b0;
      step();
      test_reset();
      test_single_rw();
      test_wrap_burst();
      test_byteenable();
      test_latency2_stall();
      test_reset_mid_burst();
      test_out_of_range();
      test_misc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
